// File: rtl/trig_holdoff_fifo_if.sv
// Trigger stream bundle: s_* is the generator side, m_* the downstream link side.
interface trig_holdoff_fifo_if;
    logic [31:0] s_trig_tdata;
    logic        s_trig_tvalid;
    logic        s_trig_tready;
    logic [31:0] m_trig_tdata;
    logic        m_trig_tvalid;
    logic        m_trig_tready;

    // master: the environment driving words in and accepting them out
    modport master (
        output s_trig_tdata, s_trig_tvalid, m_trig_tready,
        input  s_trig_tready, m_trig_tdata, m_trig_tvalid
    );

    // slave: the FIFO block itself
    modport slave (
        input  s_trig_tdata, s_trig_tvalid, m_trig_tready,
        output s_trig_tready, m_trig_tdata, m_trig_tvalid
    );
endinterface

// File: rtl/trig_holdoff_fifo.sv
// Trigger word FIFO with programmable holdoff between forwarded words.
// Optional drop counter port enabled by TRIG_HOLDOFF_DROPCNT_EN.
module trig_holdoff_fifo #(
    parameter int    DEPTH        = 16,
    parameter string DROP_ON_FULL = "FALSE"
) (
    input  logic                   ifclk,
    input  logic                   rst_i,
    input  logic                   runstop_i,
    input  logic [15:0]            holdoff_i,
    trig_holdoff_fifo_if.slave     trig,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   overflow_o
`ifdef TRIG_HOLDOFF_DROPCNT_EN
    ,
    output logic [15:0]            drop_count_o
`endif
);
    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
    localparam bit           DROP     = (DROP_ON_FULL == "TRUE");

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state, w_next;
    logic [31:0]   r_m_tdata, w_m_tdata;
    logic          r_m_tvalid, w_m_tvalid;
    logic [15:0]   r_holdcnt, w_holdcnt;
    logic          r_overflow;
    logic          w_full, w_empty, w_pop, w_wr, w_drop, w_s_tready;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Backpressure mode still reports not-ready while reset is held
    assign w_s_tready = DROP ? 1'b1 : (!rst_i && (runstop_i || !w_full));

    // A pop in the same cycle frees the slot, so a full FIFO may still accept
    assign w_wr   = trig.s_trig_tvalid && w_s_tready && !runstop_i && (!w_full || w_pop);
    assign w_drop = DROP && trig.s_trig_tvalid && w_full && !w_pop && !runstop_i;

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_m_tdata  = r_m_tdata;
        w_m_tvalid = r_m_tvalid;
        w_holdcnt  = r_holdcnt;
        case (r_state)
            IDLE: begin
                if (!w_empty && !runstop_i) begin
                    w_pop      = 1'b1;
                    w_m_tdata  = r_mem[r_rd_ptr];
                    w_m_tvalid = 1'b1;
                    w_next     = SEND;
                end
            end
            SEND: begin
                if (trig.m_trig_tready) begin
                    if (holdoff_i != 16'd0) begin
                        w_m_tvalid = 1'b0;
                        w_holdcnt  = holdoff_i;
                        w_next     = HOLD;
                    end else if (!w_empty && !runstop_i) begin
                        w_pop      = 1'b1;
                        w_m_tdata  = r_mem[r_rd_ptr];
                    end else begin
                        w_m_tvalid = 1'b0;
                        w_next     = IDLE;
                    end
                end
            end
            HOLD: begin
                w_holdcnt = r_holdcnt - 16'd1;
                if (r_holdcnt <= 16'd1) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Storage has no reset so it maps onto distributed RAM
    always_ff @(posedge ifclk) begin
        if (w_wr) r_mem[r_wr_ptr] <= trig.s_trig_tdata;
    end

    always_ff @(posedge ifclk or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= IDLE;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_holdcnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_m_tdata  <= w_m_tdata;
            r_m_tvalid <= w_m_tvalid;
            r_holdcnt  <= w_holdcnt;
            if (w_drop) r_overflow <= 1'b1;
            if (runstop_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_wr, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef TRIG_HOLDOFF_DROPCNT_EN
    logic [15:0] r_drop_cnt;
    always_ff @(posedge ifclk or posedge rst_i) begin
        if (rst_i)                              r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
    assign drop_count_o = r_drop_cnt;
`endif

    assign trig.s_trig_tready = w_s_tready;
    assign trig.m_trig_tdata  = r_m_tdata;
    assign trig.m_trig_tvalid = r_m_tvalid;
    assign fifo_count_o       = r_count;
    assign overflow_o         = r_overflow;
endmodule
